// File: rtl/intc_pkg.sv
// intc_pkg: shared types, constants and search helper for the interrupt priority arbiter.
//   state_t     : arbiter FSM states (IDLE, ARB, SEL, PEND)
//   DEF_PRIO_W  : default priority field width
//   MAX_SRC     : widest source vector the search helper accepts
//   first_from  : index of the first set bit at or after ptr, wrapping at n
package intc_pkg;

    typedef enum logic [1:0] {IDLE, ARB, SEL, PEND} state_t;

    localparam int DEF_PRIO_W = 3;
    localparam int MAX_SRC    = 256;

    // Walk downwards so the candidate closest to ptr (smallest k) is the last
    // assignment and therefore the result; empty vectors return 0.
    function automatic int first_from(input logic [MAX_SRC-1:0] vec, input int n, input int ptr);
        int idx;
        int j;
        idx = 0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n)
                    j = j - n;
                if (vec[j[$clog2(MAX_SRC)-1:0]])
                    idx = j;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_prio_max.sv
// intc_prio_max: combinational maximum priority level over the eligible sources.
//   i_elig : per-source eligibility mask
//   i_prio : packed priority levels, source i at [i*PRIO_W +: PRIO_W]
//   o_max  : highest level among eligible sources, 0 when none is eligible
module intc_prio_max
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 56,
    parameter int PRIO_W  = DEF_PRIO_W
) (
    input  logic [NUM_SRC-1:0]        i_elig,
    input  logic [NUM_SRC*PRIO_W-1:0] i_prio,
    output logic [PRIO_W-1:0]         o_max
);

    logic [PRIO_W-1:0] w_m;

    always_comb begin
        w_m = '0;
        for (int i = 0; i < NUM_SRC; i++)
            w_m = (i_elig[i] && i_prio[i*PRIO_W +: PRIO_W] > w_m) ? i_prio[i*PRIO_W +: PRIO_W] : w_m;
    end

    assign o_max = w_m;

endmodule

// File: rtl/intc_prio_arbiter.sv
// intc_prio_arbiter: latches interrupt pulses and presents the highest-priority
// pending source above the CPU mask through a valid/ack handshake.
//   clk, rst   : clock, synchronous active-high reset
//   irq_req    : per-source request pulses
//   prio       : packed per-source priority levels (0 = disabled)
//   mask_level : only sources with prio > mask_level are eligible
//   irq_ack    : CPU accepts the presented interrupt (ignored outside PEND)
//   irq_valid  : interrupt presented
//   irq_id     : winning source index
//   irq_level  : winning priority level
//   pend       : latched pending vector
// Build option: define INTC_RR_TIE_EN for round-robin resolution of equal-level
// ties; otherwise the lowest-index candidate wins and no RR pointer exists.
module intc_prio_arbiter
    import intc_pkg::*;
#(
    parameter int   NUM_SRC = 56,
    parameter int   PRIO_W  = DEF_PRIO_W,
    localparam int  ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        irq_req,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    input  logic [PRIO_W-1:0]         mask_level,
    input  logic                      irq_ack,
    output logic                      irq_valid,
    output logic [ID_W-1:0]           irq_id,
    output logic [PRIO_W-1:0]         irq_level,
    output logic [NUM_SRC-1:0]        pend
);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_SRC-1:0]  r_pend;
    logic [NUM_SRC-1:0]  r_cand;
    logic [PRIO_W-1:0]   r_max;
    logic [ID_W-1:0]     r_id;
    logic [PRIO_W-1:0]   r_level;
    logic [NUM_SRC-1:0]  w_elig;
    logic [NUM_SRC-1:0]  w_cand;
    logic [NUM_SRC-1:0]  w_clr;
    logic [PRIO_W-1:0]   w_max;
    logic [ID_W-1:0]     w_win;
    logic                w_ld_max;
    logic                w_ld_cand;
    logic                w_ld_win;
    logic                w_ack;

    always_comb begin
        w_elig = '0;
        w_cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = r_pend[i] && prio[i*PRIO_W +: PRIO_W] != '0 && prio[i*PRIO_W +: PRIO_W] > mask_level;
            w_cand[i] = w_elig[i] && prio[i*PRIO_W +: PRIO_W] == r_max;
        end
    end

    intc_prio_max #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_max (
        .i_elig  (w_elig),
        .i_prio  (prio),
        .o_max   (w_max)
    );

`ifdef INTC_RR_TIE_EN
    logic [ID_W-1:0] r_rr;

    assign w_win = ID_W'(first_from(MAX_SRC'(r_cand), NUM_SRC, int'(r_rr)));

    always_ff @(posedge clk) begin
        if (rst)
            r_rr <= '0;
        else if (w_ack)
            r_rr <= (r_id == ID_W'(NUM_SRC - 1)) ? '0 : r_id + 1'b1;
    end
`else
    assign w_win = ID_W'(first_from(MAX_SRC'(r_cand), NUM_SRC, 0));
`endif

    // Preemption compares against the presented level, not the sampled max,
    // so an equal-level newcomer never bumps the current winner.
    always_comb begin
        w_next    = r_state;
        w_ld_max  = 1'b0;
        w_ld_cand = 1'b0;
        w_ld_win  = 1'b0;
        w_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                w_ld_max = |w_elig;
                w_next   = |w_elig ? ARB : IDLE;
            end
            ARB: begin
                w_ld_cand = 1'b1;
                w_next    = |w_elig ? SEL : IDLE;
            end
            SEL: begin
                w_ld_win = |r_cand;
                w_next   = |r_cand ? PEND : IDLE;
            end
            PEND: begin
                if (irq_ack) begin
                    w_ack  = 1'b1;
                    w_next = IDLE;
                end else if (w_max > r_level) begin
                    w_ld_max = 1'b1;
                    w_next   = ARB;
                end else if (!w_elig[r_id]) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_clr = w_ack ? (NUM_SRC'(1) << r_id) : '0;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // A request arriving in the same cycle as the ack of that source survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_cand  <= '0;
            r_max   <= '0;
            r_id    <= '0;
            r_level <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | irq_req;
            if (w_ld_max)
                r_max <= w_max;
            if (w_ld_cand)
                r_cand <= w_cand;
            if (w_ld_win) begin
                r_id    <= w_win;
                r_level <= r_max;
            end
        end
    end

    assign irq_valid = (r_state == PEND);
    assign irq_id    = r_id;
    assign irq_level = r_level;
    assign pend      = r_pend;

endmodule
